snow64_serial_alu: RTL and testbench
====================================

SNOW64_SERIAL_ALU -- requirements
Module: snow64_serial_alu

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 64 bits, processed as 8 byte slices.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_start  input  1  request a new operation; sampled only in IDLE.
REQ-005 in_oper  input  3  operation: 0 Add, 1 Sub, 2 Slt, 3 And, 4 Orr, 5 Xor, 6 Inv, 7 Not.
REQ-006 in_type_size  input  2  lane size: 0 = 8-bit, 1 = 16-bit, 2 = 32-bit, 3 = 64-bit.
REQ-007 in_a, in_b  input  64 each  operands; byte i is bits [8i+7:8i].
REQ-008 out_busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-009 out_valid  output  1  one-cycle pulse marking out_data as final.
REQ-010 out_data  output  64  result register; holds its value until the next accepted start.

Function
REQ-011 States SHALL be IDLE, RUN and DONE.
- IDLE -> RUN when in_start = 1.
- RUN -> DONE after byte index 7 is processed.
- DONE -> IDLE after one cycle.
REQ-012 On an accepted start the block SHALL latch in_oper, in_type_size, in_a and in_b, clear out_data, clear the byte index to 0 and clear the carry and zero-tracking registers.
REQ-013 In RUN the block SHALL process exactly one byte per cycle, byte index 0..7 ascending; inputs changing during RUN SHALL have no effect.
REQ-014 A byte is "lane-first" when index mod (lane bytes) = 0 and "lane-last" when index mod (lane bytes) = lane bytes - 1, where lane bytes = 1, 2, 4 or 8.
REQ-015 Add: byte result = a + b + cin, where cin = 0 on a lane-first byte, otherwise the registered carry-out of the previous byte.
REQ-016 Sub: byte result = a + ~b + cin, where cin = 1 on a lane-first byte, otherwise the previous carry-out (true two's-complement subtract per lane).
REQ-017 Slt: per byte, the subtract of REQ-016 SHALL be computed without writing out_data. On a lane-last byte, the whole lane SHALL be written as zero-extended 1 when the signed values satisfy lane a < lane b, else 0. Signed less-than = (a_msb != b_msb) ? a_msb : diff_msb, taken from the lane-last byte.
REQ-018 And/Orr/Xor/Inv: bytewise a&b, a|b, a^b, ~a; no carry used.
REQ-019 Not: a zero-tracking flag SHALL be set on a lane-first byte and ANDed with (a byte == 0) on each byte. On a lane-last byte, the lane SHALL be written as zero-extended 1 if the whole lane of a is zero, else 0.
REQ-020 Carry out of every byte SHALL be registered for the next byte; the final carry-out SHALL be discarded (no overflow output).
REQ-021 out_valid SHALL be 1 only in DONE. out_data becomes final 9 cycles after the start-accept edge, and out_valid is high during the cycle after the byte-7 edge.
REQ-022 in_start while out_busy = 1 SHALL be ignored, with no queuing. in_start in the DONE cycle SHALL also be ignored; back-to-back throughput is one operation per 10 cycles.
REQ-023 Undefined encodings do not exist, since all 3-bit opers and 2-bit sizes are defined; no X SHALL propagate to outputs.

Reset
REQ-024 While rst = 1, regardless of clock:
- state = IDLE;
- out_busy = 0, out_valid = 0, out_data = 0;
- byte index, carry and zero-tracking registers = 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no out_valid pulse. After release, the block SHALL accept a start on the first clock edge.

Verification
REQ-026 Add with a = 0x00000000000000FF, b = 0x0000000000000001:
- size 8 -> 0x0000000000000000;
- size 16 -> 0x0000000000000100;
- out_valid pulses exactly once, 9 cycles after start.
REQ-027 Sub with size 64, a = 0, b = 1 -> 0xFFFFFFFFFFFFFFFF. Sub with size 8, a = 0x0000000000000100, b = 0x0000000000000001 -> 0x00000000000001FF (no borrow across lanes).
REQ-028 Slt with size 32, a = 0xFFFFFFFF00000001, b = 0x0000000000000002 -> 0x0000000100000001. The same operation with a and b swapped -> 0x0000000000000000.
REQ-029 Not with size 16, a = 0x0000000100000100 -> 0x0001000000010000. Inv with size 64, a = 0 -> 0xFFFFFFFFFFFFFFFF.
REQ-030 Handshake and reset:
- in_start held high for 30 cycles -> exactly 3 out_valid pulses, 10 cycles apart.
- rst asserted at byte index 4 -> outputs 0 immediately and no out_valid.
- After release, a new Add of 1 + 1, size 64 -> 0x0000000000000002.

Source files
------------

// File: rtl/snow64_serial_alu.sv
// Byte-serial 64-bit ALU: one byte slice per cycle over 8/16/32/64-bit lanes.
// Carry and zero flags are chained between bytes within a lane.
module snow64_serial_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_start,
  input  logic [2:0]  in_oper,
  input  logic [1:0]  in_type_size,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  output logic        out_busy,
  output logic        out_valid,
  output logic [63:0] out_data
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_SLT = 3'd2, OP_AND = 3'd3,
                         OP_ORR = 3'd4, OP_XOR = 3'd5, OP_INV = 3'd6, OP_NOT = 3'd7;

  state_t      state;
  logic [2:0]  idx;
  logic        carry;
  logic        zflag;
  logic [2:0]  oper_q;
  logic [1:0]  size_q;
  logic [63:0] a_q;
  logic [63:0] b_q;

  logic [2:0]  lane_mask;
  logic        lane_first;
  logic        lane_last;
  logic [7:0]  a_byte;
  logic [7:0]  b_byte;
  logic        is_sub;
  logic        cin;
  logic [8:0]  sum;
  logic        slt_bit;
  logic        zcur;
  logic [7:0]  logic_res;
  logic [5:0]  bit_pos;
  logic [5:0]  lane_pos;

  always_comb begin
    lane_mask = 3'd0;
    case (size_q)
      2'd0: lane_mask = 3'd0;
      2'd1: lane_mask = 3'd1;
      2'd2: lane_mask = 3'd3;
      default: lane_mask = 3'd7;
    endcase
  end

  assign lane_first = (idx & lane_mask) == 3'd0;
  assign lane_last  = (idx & lane_mask) == lane_mask;
  assign bit_pos    = {idx, 3'b000};
  // Slt and Not write their flag into the lowest byte of the lane; upper bytes stay cleared.
  assign lane_pos   = {idx & ~lane_mask, 3'b000};
  assign a_byte     = a_q[bit_pos +: 8];
  assign b_byte     = b_q[bit_pos +: 8];
  assign is_sub     = (oper_q == OP_SUB) || (oper_q == OP_SLT);
  assign cin        = lane_first ? is_sub : carry;
  assign sum        = {1'b0, a_byte} + {1'b0, (is_sub ? ~b_byte : b_byte)} + {8'd0, cin};
  assign slt_bit    = (a_byte[7] != b_byte[7]) ? a_byte[7] : sum[7];
  assign zcur       = (lane_first ? 1'b1 : zflag) & (a_byte == 8'd0);

  always_comb begin
    logic_res = 8'd0;
    case (oper_q)
      OP_AND:  logic_res = a_byte & b_byte;
      OP_ORR:  logic_res = a_byte | b_byte;
      OP_XOR:  logic_res = a_byte ^ b_byte;
      OP_INV:  logic_res = ~a_byte;
      default: logic_res = sum[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 3'd0;
      carry     <= 1'b0;
      zflag     <= 1'b0;
      oper_q    <= 3'd0;
      size_q    <= 2'd0;
      a_q       <= 64'd0;
      b_q       <= 64'd0;
      out_busy  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_start) begin
            state    <= RUN;
            oper_q   <= in_oper;
            size_q   <= in_type_size;
            a_q      <= in_a;
            b_q      <= in_b;
            out_data <= 64'd0;
            idx      <= 3'd0;
            carry    <= 1'b0;
            zflag    <= 1'b0;
            out_busy <= 1'b1;
          end
        end
        RUN: begin
          carry <= sum[8];
          zflag <= zcur;
          case (oper_q)
            OP_SLT: if (lane_last) out_data[lane_pos +: 8] <= {7'd0, slt_bit};
            OP_NOT: if (lane_last) out_data[lane_pos +: 8] <= {7'd0, zcur};
            default: out_data[bit_pos +: 8] <= logic_res;
          endcase
          idx <= idx + 3'd1;
          if (idx == 3'd7) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snow64_serial_alu.sv
// Directed bench for snow64_serial_alu with hand-computed expected results.
module tb_snow64_serial_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_start;
  logic [2:0]  in_oper;
  logic [1:0]  in_type_size;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        out_busy;
  logic        out_valid;
  logic [63:0] out_data;

  int total = 0;
  int bad = 0;

  snow64_serial_alu dut (
    .clk(clk), .rst(rst), .in_start(in_start), .in_oper(in_oper),
    .in_type_size(in_type_size), .in_a(in_a), .in_b(in_b),
    .out_busy(out_busy), .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Starts one op, scrambles inputs during RUN, returns result and edges-to-valid.
  task automatic run_op(input logic [2:0] op, input logic [1:0] sz, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] res, output int lat);
    @(negedge clk);
    in_oper = op; in_type_size = sz; in_a = a; in_b = b; in_start = 1'b1;
    lat = 0; res = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      in_start = 1'b0;
      in_a = ~a; in_b = ~b; in_oper = op ^ 3'd1; in_type_size = sz ^ 2'd1;
      if (out_valid) begin lat = k; res = out_data; break; end
    end
    if (lat == 0) chk("valid_timeout", 64'd0, 64'd1);
    @(negedge clk);
    chk("valid_one_shot", {63'd0, out_valid}, 64'd0);
    chk("idle_after_done", {63'd0, out_busy}, 64'd0);
  endtask

  task automatic vec(input string tag, input logic [2:0] op, input logic [1:0] sz,
                     input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    logic [63:0] r;
    int lat;
    run_op(op, sz, a, b, r, lat);
    chk(tag, r, exp);
    chk({tag, "_lat"}, 64'(lat), 64'd9);
  endtask

  initial begin
    int pulses, first_v, last_v, gap_bad;
    logic [63:0] r;
    int lat;
    rst = 1'b1; in_start = 1'b0; in_oper = 3'd0; in_type_size = 2'd0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, out_busy}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", out_data, 64'd0);
    rst = 1'b0;

    vec("add8",   3'd0, 2'd0, 64'h00000000000000FF, 64'h0000000000000001, 64'h0000000000000000);
    vec("add16",  3'd0, 2'd1, 64'h00000000000000FF, 64'h0000000000000001, 64'h0000000000000100);
    vec("sub64",  3'd1, 2'd3, 64'h0, 64'h1, 64'hFFFFFFFFFFFFFFFF);
    vec("sub8",   3'd1, 2'd0, 64'h0000000000000100, 64'h0000000000000001, 64'h00000000000001FF);
    vec("slt32",  3'd2, 2'd2, 64'hFFFFFFFF00000001, 64'h0000000000000002, 64'h0000000100000001);
    vec("slt32s", 3'd2, 2'd2, 64'h0000000000000002, 64'hFFFFFFFF00000001, 64'h0000000000000000);
    vec("not16",  3'd7, 2'd1, 64'h0000000100000100, 64'h0, 64'h0001000000010000);
    vec("inv64",  3'd6, 2'd3, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF);
    vec("and",    3'd3, 2'd0, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_00FF, 64'h00F0_1234_0000_00BC);
    vec("orr",    3'd4, 2'd2, 64'hF000_0000_0000_000F, 64'h0F00_0000_0000_00F0, 64'hFF00_0000_0000_00FF);
    vec("xor",    3'd5, 2'd1, 64'hFFFF_0000_AAAA_5555, 64'h0F0F_0000_FFFF_5555, 64'hF0F0_0000_5555_0000);
    vec("add32c", 3'd0, 2'd2, 64'h00000001_FFFFFFFF, 64'h00000000_00000001, 64'h00000001_00000000);

    // in_start held for 30 edges: accepts every 10 cycles.
    @(negedge clk);
    in_oper = 3'd0; in_type_size = 2'd3; in_a = 64'd1; in_b = 64'd1; in_start = 1'b1;
    pulses = 0; first_v = -1; last_v = -1; gap_bad = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (out_valid) begin
        if (last_v >= 0 && k - last_v != 10) gap_bad++;
        if (first_v < 0) first_v = k;
        last_v = k;
        pulses++;
      end
    end
    in_start = 1'b0;
    chk("hold_pulses", 64'(pulses), 64'd3);
    chk("hold_gap", 64'(gap_bad), 64'd0);
    chk("hold_first", 64'(first_v), 64'd9);
    repeat (12) @(negedge clk);

    // Reset with byte index at 4.
    in_oper = 3'd0; in_type_size = 2'd3; in_a = 64'h5; in_b = 64'h7; in_start = 1'b1;
    repeat (5) @(negedge clk);
    in_start = 1'b0;
    chk("mid_busy", {63'd0, out_busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", {63'd0, out_busy}, 64'd0);
    chk("abort_data", out_data, 64'd0);
    pulses = 0;
    repeat (3) begin @(negedge clk); if (out_valid) pulses++; end
    rst = 1'b0;
    repeat (10) begin @(negedge clk); if (out_valid) pulses++; end
    chk("abort_novalid", 64'(pulses), 64'd0);

    run_op(3'd0, 2'd3, 64'd1, 64'd1, r, lat);
    chk("post_rst_add", r, 64'd2);
    chk("post_rst_lat", 64'(lat), 64'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
